// File: rtl/track_ram_pkg.sv
// Shared types and defaults for the track RAM: stream FSM states, default sizing, parity helper.
// No logic; imported by track_ram and track_ram_core.
package track_ram_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } st_state_t;

   localparam int DEF_DATA_W    = 8;
   localparam int DEF_ADDR_W    = 13;
   localparam int DEF_TRACK_LEN = 6250;

   // Even parity: the stored bit makes the total count of ones even.
   function automatic logic even_parity(input logic [63:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/track_ram_core.sv
// Single-port storage array, synchronous read with one-cycle latency; read data holds between reads.
// No backpressure; contents are deliberately not reset.
module track_ram_core
   import track_ram_pkg::*;
#(
   parameter int WORD_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            mem[addr] <= wdata;
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/track_ram.sv
// Track RAM: host port plus a ring-buffer stream reader sharing one single-port array; host always wins,
// losing stream requests are deferred once and then flagged as overrun. Reads return one cycle later. Parity: TRACK_RAM_PARITY_EN.
module track_ram
   import track_ram_pkg::*;
#(
   parameter int DATA_W    = DEF_DATA_W,
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int TRACK_LEN = DEF_TRACK_LEN
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rd_valid,
   input  logic              st_start,
   input  logic [ADDR_W-1:0] st_base,
   input  logic              st_req,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   output logic              st_wrap,
   output logic              st_overrun,
   output logic              par_err
);

`ifdef TRACK_RAM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif

   localparam logic [ADDR_W-1:0] LAST_OFF = ADDR_W'(TRACK_LEN - 1);

   st_state_t         state, state_nx;
   logic [ADDR_W-1:0] base_q, base_nx;
   logic [ADDR_W-1:0] off_q, off_nx;
   logic              ovr_q, ovr_nx;
   logic              st_rd;
   logic              wrap_nx;
   logic              wrap_q;
   logic [DATA_W-1:0] host_hold, st_hold;

   logic              core_en, core_we;
   logic [ADDR_W-1:0] core_addr;
   logic [WORD_W-1:0] core_wdata, core_rdata;

   always_comb begin
      state_nx = state;
      base_nx  = base_q;
      off_nx   = off_q;
      ovr_nx   = ovr_q;
      st_rd    = 1'b0;
      wrap_nx  = 1'b0;
      if (st_start) begin
         state_nx = ST_RUN;
         base_nx  = st_base;
         off_nx   = '0;
         ovr_nx   = 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (st_req) begin
                  if (en) state_nx = ST_PEND;
                  else    st_rd    = 1'b1;
               end
            end
            ST_PEND: begin
               // The latched request goes out on the first host-idle cycle; a new one re-arms the latch.
               if (!en) begin
                  st_rd    = 1'b1;
                  state_nx = st_req ? ST_PEND : ST_RUN;
               end else if (st_req) begin
                  ovr_nx = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (st_rd) begin
         wrap_nx = (off_q == LAST_OFF);
         off_nx  = (off_q == LAST_OFF) ? '0 : off_q + ADDR_W'(1);
      end
   end

   assign core_en   = en | st_rd;
   assign core_we   = en & ~rw;
   assign core_addr = en ? addr : base_q + off_q;

`ifdef TRACK_RAM_PARITY_EN
   assign core_wdata = {even_parity(64'(data_in)), data_in};
   assign par_err    = (rd_valid | st_valid) &
                       (even_parity(64'(core_rdata[DATA_W-1:0])) != core_rdata[DATA_W]);
`else
   assign core_wdata = data_in;
   assign par_err    = 1'b0;
`endif

   track_ram_core #(
      .WORD_W (WORD_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk   (clk),
      .en    (core_en),
      .we    (core_we),
      .addr  (core_addr),
      .wdata (core_wdata),
      .rdata (core_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         base_q    <= '0;
         off_q     <= '0;
         ovr_q     <= 1'b0;
         rd_valid  <= 1'b0;
         st_valid  <= 1'b0;
         wrap_q    <= 1'b0;
         host_hold <= '0;
         st_hold   <= '0;
      end else begin
         state    <= state_nx;
         base_q   <= base_nx;
         off_q    <= off_nx;
         ovr_q    <= ovr_nx;
         rd_valid <= en & rw;
         st_valid <= st_rd;
         wrap_q   <= wrap_nx;
         if (rd_valid) host_hold <= core_rdata[DATA_W-1:0];
         if (st_valid) st_hold   <= core_rdata[DATA_W-1:0];
      end
   end

   // The core read register is unreset, so outputs show it only while valid and a reset-cleared copy otherwise.
   assign data_out   = rd_valid ? core_rdata[DATA_W-1:0] : host_hold;
   assign st_data    = st_valid ? core_rdata[DATA_W-1:0] : st_hold;
   assign st_wrap    = wrap_q;
   assign st_overrun = ovr_q;

endmodule

// File: tb/tb_track_ram.sv
// Directed bench for track_ram: expected host/stream words are queued with their due cycle and checked on arrival.
module tb_track_ram;

   localparam int DW = 8;
   localparam int AW = 13;

   typedef struct {
      logic [DW-1:0] d;
      logic          w;
      logic          p;
      int            due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0, rw = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] data_in = '0;
   logic [DW-1:0] data_out;
   logic          rd_valid;
   logic          st_start = 1'b0;
   logic [AW-1:0] st_base = '0;
   logic          st_req = 1'b0;
   logic [DW-1:0] st_data;
   logic          st_valid, st_wrap, st_overrun, par_err;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t hq[$];
   exp_t sq[$];

   always #5 clk = ~clk;

   track_ram #(.DATA_W(DW), .ADDR_W(AW), .TRACK_LEN(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rw(rw), .addr(addr), .data_in(data_in),
      .data_out(data_out), .rd_valid(rd_valid), .st_start(st_start), .st_base(st_base),
      .st_req(st_req), .st_data(st_data), .st_valid(st_valid), .st_wrap(st_wrap),
      .st_overrun(st_overrun), .par_err(par_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic push_h(input logic [DW-1:0] d, input logic p, input int lat);
      exp_t e;
      e.d = d; e.w = 1'b0; e.p = p; e.due = cyc + lat;
      hq.push_back(e);
   endtask

   task automatic push_s(input logic [DW-1:0] d, input logic w, input int lat);
      exp_t e;
      e.d = d; e.w = w; e.p = 1'b0; e.due = cyc + lat;
      sq.push_back(e);
   endtask

   task automatic check_cycle();
      exp_t e;
      logic exp_rd, exp_st;
      exp_rd = (hq.size() > 0) && (hq[0].due == cyc);
      exp_st = (sq.size() > 0) && (sq[0].due == cyc);
      chk("rd_valid", rd_valid, exp_rd);
      chk("st_valid", st_valid, exp_st);
      if (exp_rd) begin
         e = hq.pop_front();
         chk("data_out", data_out, e.d);
         chk("par_err_host", par_err, e.p);
      end
      if (exp_st) begin
         e = sq.pop_front();
         chk("st_data", st_data, e.d);
         chk("st_wrap", st_wrap, e.w);
      end else begin
         chk("st_wrap_idle", st_wrap, 1'b0);
      end
      if (!exp_rd && !exp_st) chk("par_err_idle", par_err, 1'b0);
   endtask

   task automatic cycle(input logic i_en, input logic i_rw, input logic [AW-1:0] i_addr,
                        input logic [DW-1:0] i_din, input logic i_start, input logic i_req);
      en = i_en; rw = i_rw; addr = i_addr; data_in = i_din;
      st_start = i_start; st_req = i_req;
      @(posedge clk);
      #1;
      cyc++;
      en = 1'b0; rw = 1'b0; st_start = 1'b0; st_req = 1'b0;
      check_cycle();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_data_out"}, data_out, '0);
      chk({tag, "_st_data"}, st_data, '0);
      chk({tag, "_rd_valid"}, rd_valid, 1'b0);
      chk({tag, "_st_valid"}, st_valid, 1'b0);
      chk({tag, "_st_wrap"}, st_wrap, 1'b0);
      chk({tag, "_st_overrun"}, st_overrun, 1'b0);
      chk({tag, "_par_err"}, par_err, 1'b0);
   endtask

   initial begin
      // Reset state
      #2;
      check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #4;

      // Stream request while IDLE is ignored
      cycle(0, 0, '0, '0, 0, 1);
      cycle(0, 0, '0, '0, 0, 0);
      chk("idle_overrun", st_overrun, 1'b0);

      // Host write/read
      cycle(1, 0, 13'h0000, 8'hFF, 0, 0);
      cycle(1, 0, 13'h0001, 8'hAA, 0, 0);
      push_h(8'hFF, 1'b0, 1); cycle(1, 1, 13'h0000, '0, 0, 0);
      push_h(8'hAA, 1'b0, 1); cycle(1, 1, 13'h0001, '0, 0, 0);
      cycle(0, 1, 13'h0000, '0, 0, 0);
      chk("data_out_hold", data_out, 8'hAA);

      // en=0 performs no write
      cycle(0, 0, 13'h0000, 8'h55, 0, 0);
      push_h(8'hFF, 1'b0, 1); cycle(1, 1, 13'h0000, '0, 0, 0);

      // Ring preload across the top of the address space, then walk past the wrap
      cycle(1, 0, 13'h1FFE, 8'd1, 0, 0);
      cycle(1, 0, 13'h1FFF, 8'd2, 0, 0);
      cycle(1, 0, 13'h0000, 8'd3, 0, 0);
      cycle(1, 0, 13'h0001, 8'd4, 0, 0);
      st_base = 13'h1FFE;
      cycle(0, 0, '0, '0, 1, 0);
      push_s(8'd1, 1'b0, 1); cycle(0, 0, '0, '0, 0, 1);
      push_s(8'd2, 1'b0, 1); cycle(0, 0, '0, '0, 0, 1);
      push_s(8'd3, 1'b0, 1); cycle(0, 0, '0, '0, 0, 1);
      push_s(8'd4, 1'b1, 1); cycle(0, 0, '0, '0, 0, 1);
      push_s(8'd1, 1'b0, 1); cycle(0, 0, '0, '0, 0, 1);
      cycle(0, 0, '0, '0, 0, 0);
      chk("st_data_hold", st_data, 8'd1);

      // st_start beats st_req; the restarted stream begins at the base again
      cycle(0, 0, '0, '0, 1, 1);
      // Write then stream-read the same word on the next cycle
      cycle(1, 0, 13'h1FFE, 8'h77, 0, 0);
      push_s(8'h77, 1'b0, 1); cycle(0, 0, '0, '0, 0, 1);

      // Collision: host read wins, stream word follows one cycle later
      push_h(8'd3, 1'b0, 1);
      push_s(8'd2, 1'b0, 2);
      cycle(1, 1, 13'h0000, '0, 0, 1);
      cycle(0, 0, '0, '0, 0, 0);
      chk("no_overrun_yet", st_overrun, 1'b0);

      // Requests under continuous host traffic: one deferred, the next lost
      cycle(1, 0, 13'h0100, 8'h5A, 0, 1);
      chk("overrun_after_first", st_overrun, 1'b0);
      cycle(1, 0, 13'h0101, 8'h5B, 0, 1);
      chk("overrun_set", st_overrun, 1'b1);
      cycle(1, 0, 13'h0102, 8'h5C, 0, 0);
      chk("overrun_sticky", st_overrun, 1'b1);
      cycle(0, 0, '0, '0, 1, 0);
      chk("overrun_cleared", st_overrun, 1'b0);

      // Asynchronous reset while a request is pending
      push_h(8'h5A, 1'b0, 1);
      cycle(1, 1, 13'h0100, '0, 0, 1);
      chk("pre_reset_data", data_out, 8'h5A);
      #2 rst_n = 1'b0;
      #1;
      check_all_zero("async_reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #4;
      cycle(0, 0, '0, '0, 0, 1);
      cycle(0, 0, '0, '0, 0, 0);
      chk("post_reset_overrun", st_overrun, 1'b0);
      push_h(8'd2, 1'b0, 1); cycle(1, 1, 13'h1FFF, '0, 0, 0);
      push_h(8'd4, 1'b0, 1); cycle(1, 1, 13'h0001, '0, 0, 0);
      push_h(8'h5B, 1'b0, 1); cycle(1, 1, 13'h0101, '0, 0, 0);

      // Parity: clean word reads without error; a corrupted stored bit is flagged
      cycle(1, 0, 13'h0005, 8'h0F, 0, 0);
      push_h(8'h0F, 1'b0, 1); cycle(1, 1, 13'h0005, '0, 0, 0);
`ifdef TRACK_RAM_PARITY_EN
      dut.u_core.mem[5] = dut.u_core.mem[5] ^ 9'h001;
      push_h(8'h0E, 1'b1, 1); cycle(1, 1, 13'h0005, '0, 0, 0);
`endif
      cycle(0, 0, '0, '0, 0, 0);

      chk("host_queue_empty", hq.size(), 0);
      chk("stream_queue_empty", sq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/track_ram.md
TRACK_RAM -- requirements
Module: track_ram

Interface
REQ-001 Parameter DATA_W, 8, word width in bits.
REQ-002 Parameter ADDR_W, 13, address width; depth SHALL be 2**ADDR_W words.
REQ-003 Parameter TRACK_LEN, 6250, stream ring length in words (1..2**ADDR_W).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 en  in  1  host access enable.
REQ-007 rw  in  1  host direction: 1 = read, 0 = write.
REQ-008 addr  in  ADDR_W  host word address.
REQ-009 data_in  in  DATA_W  host write data.
REQ-010 data_out  out  DATA_W  host read data.
REQ-011 rd_valid  out  1  data_out valid this cycle.
REQ-012 st_start  in  1  pulse; load stream pointer from st_base.
REQ-013 st_base  in  ADDR_W  stream ring base address.
REQ-014 st_req  in  1  request next stream word.
REQ-015 st_data  out  DATA_W  stream read data.
REQ-016 st_valid  out  1  st_data valid this cycle.
REQ-017 st_wrap  out  1  with st_valid; word returned is last of ring (index pulse).
REQ-018 st_overrun  out  1  sticky; stream request lost.
REQ-019 par_err  out  1  parity mismatch on the word returned with rd_valid or st_valid.

Function
REQ-020 Host write (en=1, rw=0) SHALL store data_in at addr on the same edge; rd_valid stays 0.
REQ-021 Host read (en=1, rw=1) SHALL present mem[addr] on data_out with rd_valid=1 exactly one cycle later; data_out holds last value otherwise.
REQ-022 en=0 SHALL perform no access regardless of rw, addr, data_in.
REQ-023 Storage SHALL be single-ported: at most one access (host or stream) per cycle.
REQ-024 Stream FSM states IDLE, RUN, PEND; st_start from any state -> RUN, pointer=st_base, offset=0, st_overrun cleared.
REQ-025 RUN, st_req=1, en=0: read mem[pointer]; st_data/st_valid one cycle later; pointer advances.
REQ-026 RUN, st_req=1, en=1: host wins; request latched, RUN -> PEND.
REQ-027 PEND, en=0: serve latched request, PEND -> RUN; st_req in same cycle is latched again (stay PEND).
REQ-028 PEND, st_req=1 while latched request outstanding and en=1: st_overrun set; request dropped.
REQ-029 Pointer advance: offset increments; at offset TRACK_LEN-1 the read SHALL assert st_wrap with its st_valid and offset returns to 0; address = (st_base + offset) mod 2**ADDR_W.
REQ-030 st_req in IDLE SHALL be ignored (no read, no overrun).
REQ-031 Host write and stream read of same address in consecutive cycles: stream SHALL return the newly written value.
REQ-032 st_start and st_req in the same cycle: st_start wins; st_req ignored.

Reset
REQ-033 rst_n=0 SHALL immediately force data_out=0, st_data=0, rd_valid=0, st_valid=0, st_wrap=0, st_overrun=0, par_err=0, FSM=IDLE, offset=0, pending cleared.
REQ-034 Memory contents SHALL NOT be cleared by reset; an access in flight at reset is discarded.

Configuration
REQ-035 Macro TRACK_RAM_PARITY_EN defined: each word stores an extra even-parity bit computed on write; par_err=1 with a valid read whose stored parity mismatches.
REQ-036 Macro undefined: storage is DATA_W wide, par_err tied 0.

Structure
REQ-037 Package track_ram_pkg SHALL hold the FSM state enum, default parameter constants and the parity function.
REQ-038 Storage array SHALL be the sub-module track_ram_core (single-port, synchronous read, one-cycle latency); arbitration/FSM in track_ram.

Verification
REQ-039 Write 0xFF @0, 0xAA @1, read @0 then @1 -> data_out 0xFF then 0xAA, each one cycle after request, rd_valid pulses.
REQ-040 en=0, rw=0, data_in 0x55 @0 then read @0 -> 0xFF unchanged.
REQ-041 TRACK_LEN=4, st_base=0x1FFE, mem preloaded 1,2,3,4; st_start then 5 st_req -> st_data 1,2,3,4,1; st_wrap with 4; addresses 1FFE,1FFF,0000,0001,1FFE.
REQ-042 st_req with host read same cycle -> host data next cycle, stream data cycle after; two more st_req under continuous en=1 -> st_overrun=1, cleared by st_start.
REQ-043 rst_n low mid-stream in PEND -> all outputs 0 asynchronously, FSM IDLE; prior memory readable after release.
REQ-044 With TRACK_RAM_PARITY_EN, force flipped bit in core @5 and read @5 -> par_err=1 with rd_valid; without macro par_err stays 0.
